// File: rtl/synth_midi_pkg.sv
// synth_midi_pkg
// Shared types and helpers for the MIDI transmit path: event type encoding,
// MIDI status nibbles, message length lookup, the buffered event record and
// the transmit FSM state type.
package synth_midi_pkg;

  typedef enum logic [2:0] {
    EV_NOTE_OFF   = 3'd0,
    EV_NOTE_ON    = 3'd1,
    EV_CTRL       = 3'd2,
    EV_PRG        = 3'd3,
    EV_PITCH      = 3'd4,
    EV_CHAN_PRESS = 3'd5
  } ev_type_t;

  // Upper nibble of the MIDI status byte for each event type.
  localparam logic [3:0] ST_NOTE_OFF   = 4'h8;
  localparam logic [3:0] ST_NOTE_ON    = 4'h9;
  localparam logic [3:0] ST_CTRL       = 4'hB;
  localparam logic [3:0] ST_PRG        = 4'hC;
  localparam logic [3:0] ST_CHAN_PRESS = 4'hD;
  localparam logic [3:0] ST_PITCH      = 4'hE;

  // One buffered channel-voice event; data bytes are already 7-bit clean.
  typedef struct packed {
    ev_type_t    ev_type;
    logic [3:0]  ch;
    logic [7:0]  d1;
    logic [7:0]  d2;
  } midi_ev_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ST   = 2'd1,
    S_D1   = 2'd2,
    S_D2   = 2'd3
  } tx_state_t;

  // Types 6 and 7 have no MIDI meaning and are never stored.
  function automatic logic ev_type_ok(input logic [2:0] t);
    return t <= 3'd5;
  endfunction

  // Total bytes on the wire including the status byte.
  function automatic logic [1:0] msg_len(input ev_type_t t);
    case (t)
      EV_PRG, EV_CHAN_PRESS: return 2'd2;
      default:               return 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] status_nibble(input ev_type_t t);
    case (t)
      EV_NOTE_OFF:   return ST_NOTE_OFF;
      EV_NOTE_ON:    return ST_NOTE_ON;
      EV_CTRL:       return ST_CTRL;
      EV_PRG:        return ST_PRG;
      EV_PITCH:      return ST_PITCH;
      default:       return ST_CHAN_PRESS;
    endcase
  endfunction

endpackage

// File: rtl/midi_ev_fifo.sv
// midi_ev_fifo
// Synchronous FIFO of midi_ev_t records with registered full/empty flags.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write request and record (ignored when full unless popping)
//   pop, rdata      read request; rdata shows the head combinationally
//   full, empty     registered status flags
//   count           number of records held (0..DEPTH)
module midi_ev_fifo
  import synth_midi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  midi_ev_t      wdata,
  input  logic          pop,
  output midi_ev_t      rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  midi_ev_t         mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_d;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot being written.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count;
    case ({do_push, do_pop})
      2'b10:   count_d = count + 1'b1;
      2'b01:   count_d = count - 1'b1;
      default: ;
    endcase
  end

  // NOTE: the storage array has no reset; only pointers and flags decide
  // what is valid, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_d;
      full  <= (count_d == DEPTH_C);
      empty <= (count_d == '0);
    end
  end

endmodule

// File: rtl/midi_tx_encoder.sv
// midi_tx_encoder
// Buffers channel-voice events and serialises each into MIDI bytes
// (status, data1, optional data2) for the MIDI UART transmitter.
// Optional feature: define MIDI_RUNNING_STATUS_EN to omit a status byte that
// equals the last one sent (rs_clear forgets it); otherwise every message
// carries its status byte and rs_clear is ignored.
// Ports:
//   CLOCK_50, reset_reg_N     clock, asynchronous active-low reset
//   ev_valid/ev_ready         event handshake; ev_ready = FIFO not full
//   ev_type/ev_ch/ev_data1/2  event fields (types 6-7 are dropped)
//   rs_clear                  forget running status (feature builds only)
//   midi_out_ready            UART holding register empty
//   midi_send_byte            single-cycle byte strobe
//   midi_out_data             byte, valid with the strobe and held after it
//   busy                      FSM active or FIFO not empty
//   fifo_count                events buffered
//   ev_dropped                pulse when an invalid type is offered
module midi_tx_encoder
  import synth_midi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic               CLOCK_50,
  input  logic               reset_reg_N,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic [2:0]         ev_type,
  input  logic [3:0]         ev_ch,
  input  logic [7:0]         ev_data1,
  input  logic [7:0]         ev_data2,
  input  logic               rs_clear,
  input  logic               midi_out_ready,
  output logic               midi_send_byte,
  output logic [7:0]         midi_out_data,
  output logic               busy,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               ev_dropped
);

  tx_state_t  state_q, state_d;
  midi_ev_t   msg_q;
  midi_ev_t   fifo_wdata;
  midi_ev_t   fifo_rdata;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic       holdoff_q;
  logic [7:0] data_q;
  logic [7:0] status_byte;
  logic [7:0] tx_byte;
  logic       send;
  logic       can_send;
  logic       rs_skip;

  // ---------------------------------------------------------------- intake
  assign ev_ready   = !fifo_full;
  assign fifo_push  = ev_valid && ev_ready && ev_type_ok(ev_type);
  assign ev_dropped = ev_valid && ev_ready && !ev_type_ok(ev_type);

  always_comb begin
    fifo_wdata.ev_type = ev_type_t'(ev_type);
    fifo_wdata.ch      = ev_ch;
    fifo_wdata.d1      = ev_data1 & 8'h7F;
    fifo_wdata.d2      = ev_data2 & 8'h7F;
  end

  midi_ev_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (CLOCK_50),
    .rst_n (reset_reg_N),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // -------------------------------------------------------- running status
  assign status_byte = {status_nibble(msg_q.ev_type), msg_q.ch};

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status_q;

  // A clear in the same cycle as the comparison forces the status out.
  assign rs_skip = (status_byte == last_status_q) && !rs_clear;

  always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
    if (!reset_reg_N)                 last_status_q <= 8'h00;
    else if (rs_clear)                last_status_q <= 8'h00;
    else if (send && state_q == S_ST) last_status_q <= status_byte;
  end
`else
  logic rs_clear_unused;
  assign rs_clear_unused = rs_clear;
  assign rs_skip         = 1'b0;
`endif

  // -------------------------------------------------------------- send FSM
  // holdoff blocks the cycle after a strobe so the UART can drop ready.
  assign can_send = midi_out_ready && !holdoff_q;

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    send     = 1'b0;
    tx_byte  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = S_ST;
        end
      end
      S_ST: begin
        tx_byte = status_byte;
        if (rs_skip) begin
          state_d = S_D1;
        end else if (can_send) begin
          send    = 1'b1;
          state_d = S_D1;
        end
      end
      S_D1: begin
        tx_byte = msg_q.d1;
        if (can_send) begin
          send    = 1'b1;
          state_d = (msg_len(msg_q.ev_type) == 2'd3) ? S_D2 : S_IDLE;
        end
      end
      S_D2: begin
        tx_byte = msg_q.d2;
        if (can_send) begin
          send    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLOCK_50 or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q   <= S_IDLE;
      msg_q     <= '0;
      holdoff_q <= 1'b0;
      data_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      holdoff_q <= send;
      if (fifo_pop) msg_q  <= fifo_rdata;
      if (send)     data_q <= tx_byte;
    end
  end

  // The byte appears with its strobe and stays on the bus until the next one.
  assign midi_send_byte = send;
  assign midi_out_data  = send ? tx_byte : data_q;
  assign busy           = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_midi_tx_encoder.sv
// tb_midi_tx_encoder
// Scoreboard bench: stimulus pushes the expected MIDI byte stream computed
// from the event rules; a monitor pops and compares on every byte strobe.
module tb_midi_tx_encoder;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ev_valid = 1'b0;
  logic [2:0]       ev_type = '0;
  logic [3:0]       ev_ch = '0;
  logic [7:0]       ev_data1 = '0;
  logic [7:0]       ev_data2 = '0;
  logic             rs_clear = 1'b0;
  logic             midi_out_ready = 1'b0;
  logic             ev_ready;
  logic             midi_send_byte;
  logic [7:0]       midi_out_data;
  logic             busy;
  logic [FIFO_AW:0] fifo_count;
  logic             ev_dropped;

  midi_tx_encoder #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) dut (
    .CLOCK_50       (clk),
    .reset_reg_N    (rst_n),
    .ev_valid       (ev_valid),
    .ev_ready       (ev_ready),
    .ev_type        (ev_type),
    .ev_ch          (ev_ch),
    .ev_data1       (ev_data1),
    .ev_data2       (ev_data2),
    .rs_clear       (rs_clear),
    .midi_out_ready (midi_out_ready),
    .midi_send_byte (midi_send_byte),
    .midi_out_data  (midi_out_data),
    .busy           (busy),
    .fifo_count     (fifo_count),
    .ev_dropped     (ev_dropped)
  );

  initial forever #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] exp_q [$];
  int         strobe_cycs [$];
  int         last_strobe_cyc = -100;
  logic [7:0] last_sent = 8'h00;
  bit         rdy_rand = 1'b0;
  logic       ready_fixed = 1'b1;
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] model_last = 8'h00;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: MIDI bytes an accepted event must produce on the wire.
  function automatic void model_event(input logic [2:0] t, input logic [3:0] ch,
                                      input logic [7:0] d1, input logic [7:0] d2);
    logic [3:0] nib;
    logic [7:0] st;
    if (t > 3'd5) return;
    case (t)
      3'd0:    nib = 4'h8;
      3'd1:    nib = 4'h9;
      3'd2:    nib = 4'hB;
      3'd3:    nib = 4'hC;
      3'd4:    nib = 4'hE;
      default: nib = 4'hD;
    endcase
    st = {nib, ch};
`ifdef MIDI_RUNNING_STATUS_EN
    if (st != model_last) exp_q.push_back(st);
    model_last = st;
`else
    exp_q.push_back(st);
`endif
    exp_q.push_back(d1 & 8'h7F);
    if (t != 3'd3 && t != 3'd5) exp_q.push_back(d2 & 8'h7F);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
`ifdef MIDI_RUNNING_STATUS_EN
    model_last = 8'h00;
`endif
  endfunction

  function automatic void model_rs_clear();
`ifdef MIDI_RUNNING_STATUS_EN
    model_last = 8'h00;
`endif
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART side: either a fixed ready level or random pacing.
  initial forever begin
    @(posedge clk);
    #1;
    midi_out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : ready_fixed;
  end

  // Monitor: compare every strobe against the scoreboard.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      last_sent       = 8'h00;
      last_strobe_cyc = -100;
    end else if (midi_send_byte) begin
      check("strobe_needs_ready", midi_out_ready, 1);
      check("strobe_spacing_ge2", (cyc - last_strobe_cyc) >= 2, 1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe: got byte 0x%0h with no byte expected (cycle %0d)",
                 midi_out_data, cyc);
      end else begin
        check("tx_byte", midi_out_data, exp_q.pop_front());
      end
      last_sent       = midi_out_data;
      last_strobe_cyc = cyc;
      strobe_cycs.push_back(cyc);
    end else begin
      check("data_hold", midi_out_data, last_sent);
    end
  end

  // Call aligned to posedge+1; returns aligned to posedge+1.
  task automatic send_event(input logic [2:0] t, input logic [3:0] ch,
                            input logic [7:0] d1, input logic [7:0] d2,
                            output bit accepted, output int acc_cyc);
    ev_valid = 1'b1;
    ev_type  = t;
    ev_ch    = ch;
    ev_data1 = d1;
    ev_data2 = d2;
    @(negedge clk);
    accepted = ev_ready;
    check("ev_dropped_on_offer", ev_dropped, (accepted && t > 3'd5) ? 1 : 0);
    if (accepted) model_event(t, ch, d1, d2);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    ev_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_idle"}, busy, 0);
  endtask

  task automatic wait_strobes(input string name, input int cnt, input int budget);
    int n = 0;
    while (strobe_cycs.size() < cnt && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_strobe_seen"}, strobe_cycs.size() >= cnt, 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_send"},    midi_send_byte, 0);
    check({name, "_data"},    midi_out_data, 8'h00);
    check({name, "_ready"},   ev_ready, 1);
    check({name, "_busy"},    busy, 0);
    check({name, "_count"},   fifo_count, 0);
    check({name, "_dropped"}, ev_dropped, 0);
  endtask

  initial begin
    bit acc;
    int acc_cyc;

    // Reset state
    rst_n = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // 1: note-on ch3 60/100 -> 93 3C 64, strobes 2 cycles apart
    strobe_cycs.delete();
    send_event(3'd1, 4'd3, 8'd60, 8'd100, acc, acc_cyc);
    check("t1_accept", acc, 1);
    wait_drain("t1", 50);
    check("t1_strobe_count", strobe_cycs.size(), 3);
    if (strobe_cycs.size() == 3) begin
      check("t1_latency", strobe_cycs[0] - acc_cyc, 1);
      check("t1_gap01", strobe_cycs[1] - strobe_cycs[0], 2);
      check("t1_gap12", strobe_cycs[2] - strobe_cycs[1], 2);
    end

    // 2: program change ch0 5/7F -> C0 05, busy falls right after
    strobe_cycs.delete();
    send_event(3'd3, 4'd0, 8'd5, 8'h7F, acc, acc_cyc);
    wait_strobes("t2", 2, 50);
    check("t2_busy_after_last", busy, 0);
    idle(4);
    check("t2_strobe_count", strobe_cycs.size(), 2);
    check("t2_drained", exp_q.size(), 0);

    // 3: ready held low; one event sits in the FSM, four fill the FIFO,
    // the next is refused; then everything drains in order.
    ready_fixed = 1'b0;
    idle(2);
    for (int i = 0; i < 6; i++) begin
      send_event(3'd0, 4'd5, 8'(60 + i), 8'd64, acc, acc_cyc);
      check($sformatf("t3_accept%0d", i), acc, (i < 5) ? 1 : 0);
    end
    check("t3_count_full", fifo_count, 4);
    check("t3_ready_low", ev_ready, 0);
    check("t3_busy", busy, 1);
    idle(5);
    check("t3_stalled_count", fifo_count, 4);
    ready_fixed = 1'b1;
    wait_drain("t3", 200);
    check("t3_count_empty", fifo_count, 0);

    // 4: running status pairs, without and with rs_clear in between
    send_event(3'd1, 4'd1, 8'd40, 8'd50, acc, acc_cyc);
    wait_drain("t4a_first", 50);
    send_event(3'd1, 4'd1, 8'd41, 8'd50, acc, acc_cyc);
    wait_drain("t4a_second", 50);
    send_event(3'd1, 4'd1, 8'd40, 8'd50, acc, acc_cyc);
    wait_drain("t4b_first", 50);
    rs_clear = 1'b1;
    idle(1);
    rs_clear = 1'b0;
    model_rs_clear();
    send_event(3'd1, 4'd1, 8'd41, 8'd50, acc, acc_cyc);
    wait_drain("t4b_second", 50);

    // 5: reset right after the status byte of a pitch message
    strobe_cycs.delete();
    send_event(3'd4, 4'd2, 8'h00, 8'h40, acc, acc_cyc);
    wait_strobes("t5", 1, 50);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("t5_midreset");
    idle(3);
    rst_n = 1'b1;
    idle(2);
    check("t5_quiet_after_reset", exp_q.size(), 0);
    send_event(3'd4, 4'd2, 8'h00, 8'h40, acc, acc_cyc);
    wait_drain("t5_fresh", 50);

    // 6: invalid type dropped; data bit 7 stripped
    strobe_cycs.delete();
    ev_valid = 1'b1;
    ev_type  = 3'd6;
    ev_ch    = 4'd7;
    ev_data1 = 8'h11;
    ev_data2 = 8'h22;
    @(negedge clk);
    check("t6_dropped_pulse", ev_dropped, 1);
    check("t6_count_same", fifo_count, 0);
    @(posedge clk);
    #1;
    ev_valid = 1'b0;
    @(negedge clk);
    check("t6_dropped_one_cycle", ev_dropped, 0);
    check("t6_count_still", fifo_count, 0);
    check("t6_not_busy", busy, 0);
    @(posedge clk);
    #1;
    idle(3);
    check("t6_no_strobe", strobe_cycs.size(), 0);
    send_event(3'd2, 4'd4, 8'hC5, 8'h80, acc, acc_cyc);
    wait_drain("t6_ctrl", 50);

    // Random traffic with random UART pacing
    rdy_rand = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send_event(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                 8'($urandom), 8'($urandom), acc, acc_cyc);
      idle($urandom_range(0, 3));
    end
    wait_drain("rand", 3000);
    rdy_rand    = 1'b0;
    ready_fixed = 1'b1;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

endmodule
